// File: rtl/gun_shot_detector_if.sv
// Pin and handshake bundle between the light-gun front end and its neighbours.
// The detector connects through the slave modport; stimulus or game-side logic uses master.
interface gun_shot_detector_if;
  logic gun_trigger;
  logic gun_photodetector;
  logic frame_start;
  logic flash_black;
  logic flash_target;
  logic shot_valid;
  logic shot_hit;
  logic busy;

  modport master (
    output gun_trigger,
    output gun_photodetector,
    output frame_start,
    input  flash_black,
    input  flash_target,
    input  shot_valid,
    input  shot_hit,
    input  busy
  );

  modport slave (
    input  gun_trigger,
    input  gun_photodetector,
    input  frame_start,
    output flash_black,
    output flash_target,
    output shot_valid,
    output shot_hit,
    output busy
  );
endinterface

// File: rtl/gun_shot_detector.sv
// Duck Hunt light-gun front end: pin conditioning, flash-frame sequencing and hit/miss verdict.
// Optional macro GUN_CHEAT_GUARD_EN adds the black frame that rejects ambient/lamp light.
module gun_shot_detector #(
  parameter int unsigned DEBOUNCE_CYCLES   = 650000,
  parameter int unsigned DETECT_MIN_CYCLES = 64,
  parameter int unsigned COOLDOWN_FRAMES   = 15
) (
  input logic            clk,
  input logic            rst,
  gun_shot_detector_if.slave gun
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned LC_W = (DETECT_MIN_CYCLES > 0) ? $clog2(DETECT_MIN_CYCLES + 1) : 1;
  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(DETECT_MIN_CYCLES);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
`ifdef GUN_CHEAT_GUARD_EN
    BLACK,
`endif
    TARGET,
    REPORT,
    COOLDOWN
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic trig_meta, trig_sync;
  logic pd_meta, pd_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_meta <= 1'b1;
      trig_sync <= 1'b1;
      pd_meta   <= 1'b0;
      pd_sync   <= 1'b0;
    end else begin
      trig_meta <= gun.gun_trigger;
      trig_sync <= trig_meta;
      pd_meta   <= gun.gun_photodetector;
      pd_sync   <= pd_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger debounce
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            trig_stable;
  logic            trig_stable_q;
  logic            press;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt        <= '0;
      trig_stable   <= 1'b1;
      trig_stable_q <= 1'b1;
    end else begin
      trig_stable_q <= trig_stable;
      if (trig_sync == trig_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        trig_stable <= trig_sync;
        db_cnt      <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Active-low trigger: a press is the stable level falling 1 -> 0.
  assign press = trig_stable_q & ~trig_stable;

  // ---------------------------------------------------------------------------
  // Shot sequencer
  // ---------------------------------------------------------------------------
  logic [LC_W-1:0] light_cnt, light_cnt_n, light_inc;
  logic            light_full;
  logic [CD_W-1:0] cd_cnt, cd_cnt_n;
  logic            hit_n;
`ifdef GUN_CHEAT_GUARD_EN
  logic            black_lit, black_lit_n;
`endif

  // The increment includes the current cycle, so the frame_start cycle itself is counted.
  always_comb begin
    light_inc  = (pd_sync && (light_cnt != LC_MAX)) ? light_cnt + LC_W'(1) : light_cnt;
    light_full = (light_inc == LC_MAX);
  end

  always_comb begin
    state_n     = state;
    light_cnt_n = light_cnt;
    cd_cnt_n    = cd_cnt;
    hit_n       = 1'b0;
`ifdef GUN_CHEAT_GUARD_EN
    black_lit_n = black_lit;
`endif
    case (state)
      IDLE: begin
        light_cnt_n = '0;
        if (press) state_n = ARM;
      end
      ARM: begin
        light_cnt_n = '0;
        if (gun.frame_start) begin
`ifdef GUN_CHEAT_GUARD_EN
          state_n = BLACK;
`else
          state_n = TARGET;
`endif
        end
      end
`ifdef GUN_CHEAT_GUARD_EN
      BLACK: begin
        light_cnt_n = light_inc;
        if (gun.frame_start) begin
          black_lit_n = light_full;
          light_cnt_n = '0;
          state_n     = TARGET;
        end
      end
`endif
      TARGET: begin
        light_cnt_n = light_inc;
        if (gun.frame_start) begin
`ifdef GUN_CHEAT_GUARD_EN
          hit_n = light_full & ~black_lit;
`else
          hit_n = light_full;
`endif
          light_cnt_n = '0;
          state_n     = REPORT;
        end
      end
      REPORT: begin
        cd_cnt_n = '0;
        state_n  = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (gun.frame_start) begin
          if (cd_cnt == CD_LAST) state_n = IDLE;
          else                   cd_cnt_n = cd_cnt + CD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      light_cnt        <= '0;
      cd_cnt           <= '0;
`ifdef GUN_CHEAT_GUARD_EN
      black_lit        <= 1'b0;
`endif
      gun.flash_target <= 1'b0;
      gun.shot_valid   <= 1'b0;
      gun.shot_hit     <= 1'b0;
      gun.busy         <= 1'b0;
    end else begin
      state            <= state_n;
      light_cnt        <= light_cnt_n;
      cd_cnt           <= cd_cnt_n;
`ifdef GUN_CHEAT_GUARD_EN
      black_lit        <= black_lit_n;
`endif
      gun.flash_target <= (state_n == TARGET);
      gun.shot_valid   <= (state_n == REPORT);
      gun.busy         <= (state_n != IDLE);
      if (state == TARGET && state_n == REPORT) gun.shot_hit <= hit_n;
    end
  end

`ifdef GUN_CHEAT_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) gun.flash_black <= 1'b0;
    else     gun.flash_black <= (state_n == BLACK);
  end
`else
  assign gun.flash_black = 1'b0;
`endif

endmodule

// File: tb/tb_gun_shot_detector.sv
// Scoreboard bench for gun_shot_detector: stimulus pushes expected verdicts, a forked monitor
// pops and checks them whenever shot_valid fires; flash widths and busy are checked too.
module tb_gun_shot_detector;

  localparam int unsigned FRAME = 100;

`ifdef GUN_CHEAT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    bit          hit;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        sb[$];

  gun_shot_detector_if gif();

  gun_shot_detector #(
    .DEBOUNCE_CYCLES  (4),
    .DETECT_MIN_CYCLES(3),
    .COOLDOWN_FRAMES  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gun(gif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    gif.frame_start = (cyc != 0) && (cyc % FRAME == 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait until cycle c has started; inputs are driven 1 ns after the edge.
  task automatic at(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    int unsigned run_b = 0, run_t = 0;
    bit          abort_b = 0, abort_t = 0;
    bit          hold_chk = 0;
    bit          last_hit = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        abort_b = 1;
        abort_t = 1;
      end
      if (hold_chk && !gif.shot_valid) begin
        chk("shot_hit_held", int'(gif.shot_hit), int'(last_hit));
        hold_chk = 0;
      end
      if (gif.shot_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_shot_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("shot_hit", int'(gif.shot_hit), int'(e.hit));
          chk("shot_valid_cycle", int'(cyc), int'(e.cyc));
          chk("busy_at_report", int'(gif.busy), 1);
          last_hit = e.hit;
          hold_chk = 1;
        end
      end
      if (gif.flash_black) begin
        if (run_b == 0) abort_b = 0;
        run_b++;
      end else if (run_b != 0) begin
        if (!abort_b) chk("flash_black_len", int'(run_b), int'(FRAME));
        run_b = 0;
      end
      if (gif.flash_target) begin
        if (run_t == 0) abort_t = 0;
        run_t++;
      end else if (run_t != 0) begin
        if (!abort_t) chk("flash_target_len", int'(run_t), int'(FRAME));
        run_t = 0;
      end
    end
  endtask

  task automatic pulse_pd(input int unsigned start, input int unsigned n);
    if (n != 0) begin
      at(start);
      gif.gun_photodetector = 1'b1;
      at(start + n);
      gif.gun_photodetector = 1'b0;
    end
  endtask

  // One shot: press at offset 10 of the next frame; light counts n (black) and m (target).
  task automatic do_shot(input int unsigned n, input int unsigned m, input bit amb,
                         input bit rp_t, input bit rp_c);
    int unsigned k, bf, tf, rf;
    bit          lit_b, lit_t;
    exp_t        e;
    k  = cyc / FRAME + 1;
    bf = k + 1;
    tf = GUARD ? k + 2 : k + 1;
    rf = tf + 1;
    lit_b = amb || (n >= 3);
    lit_t = amb || (m >= 3);
    e.hit = GUARD ? (lit_t && !lit_b) : lit_t;
    e.cyc = rf * FRAME + 1;
    at(k * FRAME + 10);
    gif.gun_trigger = 1'b0;
    sb.push_back(e);
    at(k * FRAME + 30);
    gif.gun_trigger = 1'b1;
    if (amb) begin
      at(k * FRAME + 40);
      gif.gun_photodetector = 1'b1;
    end else begin
      if (GUARD) pulse_pd(bf * FRAME + 20, n);
      pulse_pd(tf * FRAME + 20, m);
    end
    if (rp_t) begin
      at(tf * FRAME + 50);
      gif.gun_trigger = 1'b0;
      at(tf * FRAME + 70);
      gif.gun_trigger = 1'b1;
    end
    if (amb) begin
      at(rf * FRAME + 45);
      gif.gun_photodetector = 1'b0;
    end
    if (rp_c) begin
      at(rf * FRAME + 50);
      gif.gun_trigger = 1'b0;
      at(rf * FRAME + 70);
      gif.gun_trigger = 1'b1;
    end
    at((rf + 3) * FRAME);
  endtask

  int unsigned dn[6]  = '{0, 0, 0, 0, 5, 1};
  int unsigned dm[6]  = '{10, 2, 3, 0, 5, 6};
  bit          dam[6] = '{0, 0, 0, 1, 0, 0};
  bit          drt[6] = '{0, 0, 0, 0, 0, 1};
  bit          drc[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    int unsigned busy_cnt;
    int unsigned k;
    gif.gun_trigger       = 1'b1;
    gif.gun_photodetector = 1'b0;
    gif.frame_start       = 1'b0;
    fork
      monitor();
    join_none

    at(3);
    @(negedge clk);
    chk("reset_flash_black", int'(gif.flash_black), 0);
    chk("reset_flash_target", int'(gif.flash_target), 0);
    chk("reset_shot_valid", int'(gif.shot_valid), 0);
    chk("reset_shot_hit", int'(gif.shot_hit), 0);
    chk("reset_busy", int'(gif.busy), 0);
    at(5);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_shot(dn[i], dm[i], dam[i], drt[i], drc[i]);

    // Bounce: toggle every 2 cycles for 30 cycles, then released.
    k = cyc / FRAME + 1;
    at(k * FRAME + 10);
    for (int i = 0; i < 15; i++) begin
      gif.gun_trigger = ~gif.gun_trigger;
      at(k * FRAME + 12 + 2 * i);
    end
    gif.gun_trigger = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (gif.busy) busy_cnt++;
    end
    chk("bounce_busy_cycles", int'(busy_cnt), 0);

    // Reset in the middle of the target frame: no verdict may follow.
    k = cyc / FRAME + 1;
    at(k * FRAME + 10);
    gif.gun_trigger = 1'b0;
    at(k * FRAME + 30);
    gif.gun_trigger = 1'b1;
    at((k + (GUARD ? 2 : 1)) * FRAME + 40);
    chk("busy_before_abort", int'(gif.busy), 1);
    rst = 1'b1;
    at((k + (GUARD ? 2 : 1)) * FRAME + 41);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_flash_black", int'(gif.flash_black), 0);
    chk("abort_flash_target", int'(gif.flash_target), 0);
    chk("abort_shot_valid", int'(gif.shot_valid), 0);
    chk("abort_shot_hit", int'(gif.shot_hit), 0);
    chk("abort_busy", int'(gif.busy), 0);
    at(cyc + 4 * FRAME);

    for (int i = 0; i < 12; i++) begin
      do_shot($urandom_range(0, 6), $urandom_range(0, 6), ($urandom_range(0, 5) == 0),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    at(cyc + 2 * FRAME);
    chk("pending_verdicts", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
